// File: rtl/motor_pwm_driver_pkg.sv
// Shared widths, channel FSM state codes and the per-channel target request
// used by the motor PWM driver and its channel sub-module.
package motor_pwm_driver_pkg;

  localparam int CORR_W = 13;
  localparam int MIX_W  = 15;
  localparam int DUTY_W = 13;
  localparam int NUM_CH = 2;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_BRAKE = 2'd1;
  localparam logic [1:0] ST_DEAD  = 2'd2;

  typedef struct packed {
    logic              dir;
    logic [DUTY_W-1:0] mag;
  } chan_req_t;

endpackage

// File: rtl/motor_channel.sv
// One motor bridge: direction FSM, slew limiter, dead-time counter and the
// registered PWM compare. All state advances only on the period tick.
module motor_channel
  import motor_pwm_driver_pkg::*;
#(
  parameter int RAMP_STEP    = 20,
  parameter int DEAD_PERIODS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick_i,
  input  logic [DUTY_W-1:0] cnt_nxt_i,
  input  chan_req_t         req_i,
  output logic              pwm_o,
  output logic              dir_o,
  output logic [DUTY_W-1:0] duty_o
);

  localparam int DW = (DEAD_PERIODS > 1) ? $clog2(DEAD_PERIODS) : 1;
  localparam logic [DW-1:0]     DLAST = DW'(DEAD_PERIODS - 1);
  localparam logic [DUTY_W-1:0] STEP  = DUTY_W'(RAMP_STEP);

  logic [1:0]        st_q, st_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic              dir_q, dir_d;
  logic [DW-1:0]     dead_q, dead_d;
  logic              pwm_q, pwm_d;

  always_comb begin
    st_d   = st_q;
    duty_d = duty_q;
    dir_d  = dir_q;
    dead_d = dead_q;
    if (tick_i) begin
      case (st_q)
        ST_RUN: begin
          if (req_i.dir == dir_q) begin
            if (duty_q < req_i.mag)
              duty_d = (req_i.mag - duty_q > STEP) ? duty_q + STEP : req_i.mag;
            else
              duty_d = (duty_q - req_i.mag > STEP) ? duty_q - STEP : req_i.mag;
          end else begin
            st_d = ST_BRAKE;
          end
        end
        ST_BRAKE: begin
          duty_d = (duty_q > STEP) ? duty_q - STEP : '0;
          if (duty_q <= STEP) begin
            st_d   = ST_DEAD;
            dead_d = '0;
          end
        end
        ST_DEAD: begin
          duty_d = '0;
          // The flip uses the newest sample, even if it agrees with the old direction.
          if (dead_q == DLAST) begin
            dir_d = req_i.dir;
            st_d  = ST_RUN;
          end else begin
            dead_d = dead_q + 1'b1;
          end
        end
        default: st_d = ST_RUN;
      endcase
    end
  end

  // Compare against next-state values so pwm_o lines up with the visible counter.
  assign pwm_d = (cnt_nxt_i < duty_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= ST_RUN;
      duty_q <= '0;
      dir_q  <= 1'b1;
      dead_q <= '0;
      pwm_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      duty_q <= duty_d;
      dir_q  <= dir_d;
      dead_q <= dead_d;
      pwm_q  <= pwm_d;
    end
  end

  assign pwm_o  = pwm_q;
  assign dir_o  = dir_q;
  assign duty_o = duty_q;

endmodule

// File: rtl/motor_pwm_driver.sv
// PID-to-H-bridge driver: period counter, correction sampler and mixer/clamp
// feeding two motor_channel instances (index 0 = left, 1 = right).
module motor_pwm_driver
  import motor_pwm_driver_pkg::*;
#(
  parameter int PWM_PERIOD   = 1000,
  parameter int BASE_SPEED   = 600,
  parameter int RAMP_STEP    = 20,
  parameter int DEAD_PERIODS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [CORR_W-1:0] pid_output,
  output logic              period_tick,
  output logic              pwm_l,
  output logic              pwm_r,
  output logic              dir_l,
  output logic              dir_r,
  output logic [DUTY_W-1:0] duty_l,
  output logic [DUTY_W-1:0] duty_r
);

  localparam logic [DUTY_W-1:0] LAST = DUTY_W'(PWM_PERIOD - 1);
  localparam logic [DUTY_W-1:0] FULL = DUTY_W'(PWM_PERIOD);

  logic [DUTY_W-1:0] cnt_q, cnt_d;

  assign cnt_d       = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  assign period_tick = (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // 15-bit mix keeps base +/- full-range correction free of overflow.
  logic signed [MIX_W-1:0] corr, base;
  logic [NUM_CH-1:0][MIX_W-1:0] tgt;

  assign corr   = {{(MIX_W-CORR_W){pid_output[CORR_W-1]}}, pid_output};
  assign base   = MIX_W'(BASE_SPEED);
  assign tgt[0] = en ? base + corr : '0;
  assign tgt[1] = en ? base - corr : '0;

  chan_req_t   [NUM_CH-1:0]             req;
  logic        [NUM_CH-1:0]             pwm, dir;
  logic        [NUM_CH-1:0][DUTY_W-1:0] duty;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [MIX_W-1:0]  absv;
    logic [DUTY_W-1:0] mag;

    assign absv   = tgt[g][MIX_W-1] ? (~tgt[g] + 1'b1) : tgt[g];
    assign mag    = (absv > MIX_W'(PWM_PERIOD)) ? FULL : absv[DUTY_W-1:0];
    assign req[g] = {~tgt[g][MIX_W-1], mag};

    motor_channel #(
      .RAMP_STEP    (RAMP_STEP),
      .DEAD_PERIODS (DEAD_PERIODS)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .tick_i    (period_tick),
      .cnt_nxt_i (cnt_d),
      .req_i     (req[g]),
      .pwm_o     (pwm[g]),
      .dir_o     (dir[g]),
      .duty_o    (duty[g])
    );
  end

  assign pwm_l  = pwm[0];
  assign pwm_r  = pwm[1];
  assign dir_l  = dir[0];
  assign dir_r  = dir[1];
  assign duty_l = duty[0];
  assign duty_r = duty[1];

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Directed bench for motor_pwm_driver with a per-cycle reference model of the
// period counter, mixer, direction/dead-time rules and slew limiting.
module tb_motor_pwm_driver;

  localparam int P = 100;
  localparam int B = 60;
  localparam int S = 10;
  localparam int D = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic [12:0] pid = '0;
  logic        period_tick, pwm_l, pwm_r, dir_l, dir_r;
  logic [12:0] duty_l, duty_r;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 0;

  always #5 clk = ~clk;

  motor_pwm_driver #(
    .PWM_PERIOD(P), .BASE_SPEED(B), .RAMP_STEP(S), .DEAD_PERIODS(D)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .pid_output(pid),
    .period_tick(period_tick), .pwm_l(pwm_l), .pwm_r(pwm_r),
    .dir_l(dir_l), .dir_r(dir_r), .duty_l(duty_l), .duty_r(duty_r)
  );

  // Reference model: mode 0 = driving, 1 = braking, 2 = dead time.
  int m_cnt;
  int m_duty [2];
  int m_dir  [2];
  int m_mode [2];
  int m_dead [2];
  int m_pwm  [2];

  task automatic model_period();
    int c, tgt, want, mag;
    c = int'($signed(pid));
    for (int ch = 0; ch < 2; ch++) begin
      tgt  = !en ? 0 : (ch == 0 ? B + c : B - c);
      want = (tgt >= 0) ? 1 : 0;
      mag  = (tgt < 0) ? -tgt : tgt;
      if (mag > P) mag = P;
      if (m_mode[ch] == 0) begin
        if (want != m_dir[ch]) m_mode[ch] = 1;
        else if (m_duty[ch] < mag) m_duty[ch] += (mag - m_duty[ch] < S) ? mag - m_duty[ch] : S;
        else m_duty[ch] -= (m_duty[ch] - mag < S) ? m_duty[ch] - mag : S;
      end else if (m_mode[ch] == 1) begin
        m_duty[ch] -= (m_duty[ch] < S) ? m_duty[ch] : S;
        if (m_duty[ch] == 0) begin m_mode[ch] = 2; m_dead[ch] = 0; end
      end else begin
        m_duty[ch] = 0;
        if (m_dead[ch] == D - 1) begin m_dir[ch] = want; m_mode[ch] = 0; end
        else m_dead[ch]++;
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = 0;
      for (int ch = 0; ch < 2; ch++) begin
        m_duty[ch] = 0; m_dir[ch] = 1; m_mode[ch] = 0; m_dead[ch] = 0; m_pwm[ch] = 0;
      end
    end else begin
      if (m_cnt == P - 1) model_period();
      m_cnt = (m_cnt + 1) % P;
      for (int ch = 0; ch < 2; ch++) m_pwm[ch] = (m_cnt < m_duty[ch]) ? 1 : 0;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      checks++;
      if (period_tick !== (m_cnt == P - 1) || pwm_l !== m_pwm[0][0] || pwm_r !== m_pwm[1][0] ||
          dir_l !== m_dir[0][0] || dir_r !== m_dir[1][0] ||
          int'(duty_l) != m_duty[0] || int'(duty_r) != m_duty[1]) begin
        failures++;
        if (failures < 12)
          $display("FAIL model t=%0t got tick=%b pwm=%b%b dir=%b%b duty=%0d/%0d want tick=%0d pwm=%0d%0d dir=%0d%0d duty=%0d/%0d",
                   $time, period_tick, pwm_l, pwm_r, dir_l, dir_r, duty_l, duty_r,
                   (m_cnt == P - 1), m_pwm[0], m_pwm[1], m_dir[0], m_dir[1], m_duty[0], m_duty[1]);
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, got, exp);
    end
  endtask

  // Returns at the negedge just after a period boundary (new duty visible, cnt=0).
  task automatic after_tick();
    int n = 0;
    while (!period_tick && n < 3 * P) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!period_tick) begin
      failures++;
      $display("FAIL tick_timeout got=0 want=1");
    end
    @(negedge clk);
  endtask

  task automatic count_high(input string name, input int exp);
    int hi = 0;
    for (int i = 0; i < P; i++) begin
      hi += int'(pwm_l);
      if (i < P - 1) @(negedge clk);
    end
    chk(name, hi, exp);
  endtask

  initial begin
    int exp_r [14] = '{60, 50, 40, 30, 20, 10, 0, 0, 0, 10, 20, 30, 40, 40};
    repeat (3) @(negedge clk);
    cmp_en = 1;
    chk("rst_duty_l", duty_l, 0);
    chk("rst_dir_r", dir_r, 1);
    chk("rst_pwm_l", pwm_l, 0);
    chk("rst_tick", period_tick, 0);
    rst_n = 1;

    // Soft start at zero correction
    for (int k = 1; k <= 7; k++) begin
      after_tick();
      chk("t1_duty_l", duty_l, (k < 6 ? k : 6) * 10);
      chk("t1_duty_r", duty_r, (k < 6 ? k : 6) * 10);
    end
    chk("t1_dir_l", dir_l, 1);
    count_high("t1_pwm_high", 60);

    // Small positive correction
    pid = 13'd20;
    after_tick(); chk("t2_l1", duty_l, 70); chk("t2_r1", duty_r, 50);
    after_tick(); chk("t2_l2", duty_l, 80); chk("t2_r2", duty_r, 40);
    chk("t2_dir_r", dir_r, 1);
    pid = 13'd0;
    after_tick(); after_tick();
    chk("t2_back_l", duty_l, 60);

    // Right motor reverses through brake and dead time
    pid = 13'd100;
    for (int t = 0; t < 14; t++) begin
      after_tick();
      chk("t3_duty_r", duty_r, exp_r[t]);
      chk("t3_dir_r", dir_r, (t <= 7) ? 1 : 0);
      chk("t3_duty_l", duty_l, (70 + 10 * t > 100) ? 100 : 70 + 10 * t);
    end
    count_high("t3_pwm_full", 100);

    // Mid-period correction change is held until the boundary
    after_tick();
    repeat (30) @(negedge clk);
    pid = 13'd80;
    repeat (69) @(negedge clk);
    chk("t4_hold_r", duty_r, 40);
    chk("t4_tick", period_tick, 1);
    after_tick(); chk("t4_r1", duty_r, 30);
    after_tick(); chk("t4_r2", duty_r, 20);
    chk("t4_dir_r", dir_r, 0);

    // Asynchronous reset mid-period with pwm high
    repeat (50) @(negedge clk);
    chk("t5_pre_pwm", pwm_l, 1);
    pid = 13'd0;
    #2 rst_n = 0;
    #1;
    chk("t5_pwm_l", pwm_l, 0);
    chk("t5_pwm_r", pwm_r, 0);
    chk("t5_duty_l", duty_l, 0);
    chk("t5_dir_r", dir_r, 1);
    repeat (3) @(negedge clk);
    rst_n = 1;
    for (int k = 1; k <= 7; k++) begin
      after_tick();
      chk("t5_ramp_r", duty_r, (k < 6 ? k : 6) * 10);
    end

    // Disable ramps down, then extreme negative correction
    en = 1'b0;
    for (int t = 1; t <= 6; t++) begin
      after_tick();
      chk("t6_off_l", duty_l, 60 - 10 * t);
      chk("t6_off_dir", dir_l, 1);
    end
    en = 1'b1;
    pid = 13'h1000;
    for (int t = 1; t <= 14; t++) begin
      after_tick();
      if (t == 1) chk("t6_l_hold", duty_l, 0);
      if (t == 3) chk("t6_l_dir_dead", dir_l, 1);
      if (t == 4) chk("t6_l_flip", dir_l, 0);
      if (t == 10) chk("t6_r_sat", duty_r, 100);
    end
    chk("t6_l_sat", duty_l, 100);
    chk("t6_l_dir", dir_l, 0);
    chk("t6_r_dir", dir_r, 1);

    cmp_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
